// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: NUM_BTN debounced push-buttons -> MIDI Note On/Off messages on a 31.25 kbaud 8N1 line.
// Optional build macro MIDI_RUNNING_STATUS_EN: omit the status byte when it repeats the last one sent.
module midi_note_ctrl #(
  parameter int unsigned NUM_BTN       = 8,
  parameter int unsigned BAUD_CNT_HALF = 800,
  parameter int unsigned DEBOUNCE_CNT  = 250000,
  parameter int unsigned MIDI_CH       = 0,
  parameter int unsigned BASE_NOTE     = 60,
  parameter int unsigned VEL_ON        = 100,
  parameter int unsigned VEL_OFF       = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] led,
  output logic               midi_tx,
  output logic               busy
);

  localparam int unsigned BIT_LEN = 2 * BAUD_CNT_HALF;
  localparam int unsigned BW      = $clog2(BIT_LEN);
  localparam int unsigned DW      = $clog2(DEBOUNCE_CNT);
  localparam int unsigned IW      = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  typedef struct packed {
    logic [7:0] status;
    logic [7:0] note;
    logic [7:0] vel;
  } midi_msg_t;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_e;

  // Reject parameter sets that cannot form legal MIDI messages
  if (NUM_BTN < 1 || NUM_BTN > 32 || BASE_NOTE + NUM_BTN - 1 > 127 || DEBOUNCE_CNT < 2 ||
      MIDI_CH > 15 || VEL_ON < 1 || VEL_ON > 127 || VEL_OFF > 127 || BAUD_CNT_HALF < 1) begin : g_param_check
    $error("midi_note_ctrl: illegal parameter set");
  end

  logic [NUM_BTN-1:0] sync1_q, sync2_q, stable_q;
  logic [DW-1:0]      db_cnt_q [NUM_BTN];

  logic [NUM_BTN-1:0] sent_q, sent_d, pend;
  logic               scan_hit, scan_on;
  logic [IW-1:0]      scan_idx;
  midi_msg_t          scan_msg, msg_q, msg_d;

  state_e             state_q, state_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic               bit_end, skip_status;
  logic [7:0]         cur_byte_d;
  logic               tx_q, tx_d, busy_q, busy_d;

  function automatic logic [7:0] pick_byte(input midi_msg_t m, input logic [1:0] idx);
    case (idx)
      2'd0:    return m.status;
      2'd1:    return m.note;
      default: return m.vel;
    endcase
  endfunction

  // Two-flop synchroniser followed by a per-button stability counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DW'(DEBOUNCE_CNT - 1)) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Fixed-priority scan: lowest pending button wins, message formed from its debounced state
  always_comb begin
    pend     = stable_q ^ sent_q;
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend[i]) begin
        scan_hit = 1'b1;
        scan_idx = IW'(i);
      end
    end
    scan_on         = stable_q[scan_idx];
    scan_msg.status = (scan_on ? 8'h90 : 8'h80) | 8'(MIDI_CH);
    scan_msg.note   = 8'(BASE_NOTE) + 8'(scan_idx);
    scan_msg.vel    = scan_on ? 8'(VEL_ON) : 8'(VEL_OFF);
  end

  assign bit_end = (baud_q == BW'(BIT_LEN - 1));

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;
  assign skip_status   = (msg_q.status == last_status_q);
  assign last_status_d = (state_q == S_LOAD && !skip_status) ? msg_q.status : last_status_q;

  // Status byte most recently put on the line (0 = none since reset)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_status_q <= 8'h00;
    else      last_status_q <= last_status_d;
  end
`else
  assign skip_status = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: one LOAD cycle, then start/data/stop per byte with no gap
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (scan_hit) state_d = S_LOAD;
      S_LOAD:  state_d = S_START;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA:  if (bit_end && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (bit_end) state_d = (byte_idx_q < 2'd2) ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next state: message latch, sent flags, bit timer and byte/bit indices
  always_comb begin
    msg_d      = msg_q;
    sent_d     = sent_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    baud_d     = baud_q;
    case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          msg_d            = scan_msg;
          sent_d[scan_idx] = scan_on;
        end
      end
      S_LOAD: begin
        byte_idx_d = skip_status ? 2'd1 : 2'd0;
        bit_idx_d  = 3'd0;
        baud_d     = '0;
      end
      default: begin
        baud_d = bit_end ? '0 : baud_q + BW'(1);
        if (bit_end) begin
          if (state_q == S_START)     bit_idx_d  = 3'd0;
          else if (state_q == S_DATA) bit_idx_d  = bit_idx_q + 3'd1;
          else                        byte_idx_d = byte_idx_q + 2'd1;
        end
      end
    endcase
  end

  // FSM outputs, computed for the upcoming state so the registered line tracks it exactly
  always_comb begin
    cur_byte_d = pick_byte(msg_d, byte_idx_d);
    busy_d     = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Datapath and output registers; reset forces the line idle immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      msg_q      <= '0;
      sent_q     <= '0;
      byte_idx_q <= 2'd0;
      bit_idx_q  <= 3'd0;
      baud_q     <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      msg_q      <= msg_d;
      sent_q     <= sent_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      baud_q     <= baud_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign led     = stable_q;
  assign midi_tx = tx_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_midi_note_ctrl.sv
// Bench for midi_note_ctrl: spec-level reference model feeds an expected-byte queue; a UART monitor checks the line.
`timescale 1ns/1ps
module tb_midi_note_ctrl;

  localparam int unsigned NB   = 4;
  localparam int unsigned BH   = 32;
  localparam int unsigned DB   = 10;
  localparam int unsigned BIT  = 2 * BH;
  localparam int unsigned BASE = 60;
  localparam int unsigned VON  = 100;
  localparam int unsigned VOFF = 64;
  localparam int unsigned CH   = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] btn = '0;
  logic [NB-1:0] led;
  logic          midi_tx, busy;

  always #5 clk = ~clk;

  midi_note_ctrl #(
    .NUM_BTN(NB), .BAUD_CNT_HALF(BH), .DEBOUNCE_CNT(DB), .MIDI_CH(CH),
    .BASE_NOTE(BASE), .VEL_ON(VON), .VEL_OFF(VOFF)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .led(led), .midi_tx(midi_tx), .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: a button is accepted once its synchronised level has differed from the
  // accepted level for DB consecutive clocks; the sender scans only when its line is free.
  logic [NB-1:0] m_s1, m_s2, m_st, m_sent;
  int            m_run [NB];
  int            e, next_scan, load_e, end_e;
  bit            m_busy;
  logic [7:0]    m_last;

  always @(posedge clk) begin
    if (!rst) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_sent = '0;
      for (int i = 0; i < NB; i++) m_run[i] = 0;
      e = 0; next_scan = 0; load_e = 0; end_e = 0; m_busy = 0; m_last = 8'h00;
      exp_q.delete();
    end else begin
      e++;
      for (int i = 0; i < NB; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == DB) begin
            m_st[i]  = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn;
      if (e >= next_scan && m_st != m_sent) begin
        int idx;
        int nbytes;
        logic [7:0] status;
        idx = 0;
        for (int i = NB - 1; i >= 0; i--) if (m_st[i] != m_sent[i]) idx = i;
        status = (m_st[idx] ? 8'h90 : 8'h80) | 8'(CH);
        nbytes = 3;
`ifdef MIDI_RUNNING_STATUS_EN
        if (status == m_last) nbytes = 2;
        else m_last = status;
`endif
        if (nbytes == 3) exp_q.push_back(status);
        exp_q.push_back(8'(BASE + idx));
        exp_q.push_back(m_st[idx] ? 8'(VON) : 8'(VOFF));
        m_sent[idx] = m_st[idx];
        load_e    = e + 1;
        end_e     = e + 2 + nbytes * 10 * BIT;
        next_scan = end_e;
      end
      m_busy = (e >= load_e) && (e < end_e);
    end
  end

  // Per-cycle state checks plus a mid-bit sampling UART receiver that pops the scoreboard
  bit         mon_act = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst) begin
      mon_act = 0;
    end else begin
      check("led", 32'(led), 32'(m_st));
      check("busy", 32'(busy), 32'(m_busy));
      if (!mon_act) begin
        if (midi_tx == 1'b0) begin
          mon_act = 1;
          mon_cnt = 0;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_act && (mon_cnt % BIT) == BIT / 2) begin
        int k;
        k = mon_cnt / BIT;
        if (k == 0) begin
          check("start_bit", 32'(midi_tx), 32'd0);
          if (midi_tx) mon_act = 0;
        end else if (k <= 8) begin
          mon_byte[k-1] = midi_tx;
        end else begin
          check("stop_bit", 32'(midi_tx), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=0x%0h required=none at %0t", mon_byte, $time);
          end else begin
            logic [7:0] exp_b;
            exp_b = exp_q.pop_front();
            check("midi_byte", 32'(mon_byte), 32'(exp_b));
          end
          mon_act = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait until the line has been idle with nothing outstanding for a while
  task automatic wait_quiet();
    int quiet = 0;
    int t = 0;
    while (quiet < 60 && t < 40000) begin
      @(negedge clk);
      t++;
      if (!busy && exp_q.size() == 0 && m_st == m_sent) quiet++;
      else quiet = 0;
    end
    check("drain_done", 32'(quiet >= 60), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b0;
    btn = '0;
    #20;
    check("rst_midi_tx", 32'(midi_tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick(3);

    // Single press: debounce latency, request latency, message length
    btn[0] = 1'b1;
    n = 0;
    while (!led[0] && n < 100) begin @(negedge clk); n++; end
    check("debounce_latency", 32'(n), 32'd12);
    n = 0;
    while (!busy && n < 10) begin @(negedge clk); n++; end
    check("busy_latency", 32'(n), 32'd1);
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    check("busy_length", 32'(n), 32'(60 * BH + 1));
    wait_quiet();

    // Release, then two simultaneous presses served in priority order
    btn[0] = 1'b0;
    wait_quiet();
    btn[3] = 1'b1;
    btn[1] = 1'b1;
    wait_quiet();

    // Short glitch must be ignored
    btn[2] = 1'b1;
    tick(5);
    btn[2] = 1'b0;
    tick(30);
    check("glitch_led", 32'(led[2]), 32'd0);
    check("glitch_busy", 32'(busy), 32'd0);

    // Press and release of btn[2] completed while another message is on the line
    btn[3] = 1'b0;
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    check("busy_seen", 32'(busy), 32'd1);
    btn[2] = 1'b1;
    tick(20);
    btn[2] = 1'b0;
    tick(20);
    btn[1] = 1'b0;
    wait_quiet();

    // Randomised button activity including sub-debounce glitches
    repeat (60) begin
      btn[$urandom_range(0, NB - 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 8));
      else tick($urandom_range(10, 250));
    end
    btn = '0;
    wait_quiet();

    // Reset in the middle of a data byte
    btn[0] = 1'b1;
    n = 0;
    while (!busy && n < 100) begin @(negedge clk); n++; end
    check("busy_before_abort", 32'(busy), 32'd1);
    tick(100);
    #2;
    rst = 1'b0;
    btn = '0;
    #1;
    check("abort_midi_tx", 32'(midi_tx), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    tick(3);
    rst = 1'b1;
    tick(3000);
    check("post_abort_led", 32'(led), 32'd0);
    check("post_abort_busy", 32'(busy), 32'd0);

    // Two consecutive presses (status repeats)
    btn[0] = 1'b1;
    wait_quiet();
    btn[1] = 1'b1;
    wait_quiet();
    btn = '0;
    wait_quiet();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
